// File: rtl/freq_ctrl_pkg.sv
// Shared constants, FSM encoding and the step/clamp helper for the frequency key controller.
// Build option: define FREQ_WRAP_EN to wrap between the limits instead of saturating.
package freq_ctrl_pkg;

    localparam int FREQ_W = 7;

    localparam logic [FREQ_W-1:0] FREQ_MIN_DEF  = 7'd20;
    localparam logic [FREQ_W-1:0] FREQ_MAX_DEF  = 7'd50;
    localparam logic [FREQ_W-1:0] FREQ_INIT_DEF = 7'd20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    // One +1/-1 step, done one bit wider so the limit test cannot overflow first.
    function automatic logic [FREQ_W-1:0] step_freq(
        input logic [FREQ_W-1:0] cur,
        input logic              up,
        input logic [FREQ_W-1:0] fmin,
        input logic [FREQ_W-1:0] fmax
    );
        logic [FREQ_W:0]   wide;
        logic [FREQ_W-1:0] res;
        if (up) begin
            wide = {1'b0, cur} + (FREQ_W+1)'(1);
            if (wide > {1'b0, fmax}) begin
`ifdef FREQ_WRAP_EN
                res = fmin;
`else
                res = fmax;
`endif
            end else begin
                res = wide[FREQ_W-1:0];
            end
        end else begin
            wide = {1'b0, cur} - (FREQ_W+1)'(1);
            if (cur <= fmin) begin
`ifdef FREQ_WRAP_EN
                res = fmax;
`else
                res = fmin;
`endif
            end else begin
                res = wide[FREQ_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button.
// Outputs the debounced pressed level and a one-cycle pulse when it becomes pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_0;
    logic             sync_1;
    logic             level_n;
    logic [CNT_W-1:0] cnt;

    // The level only flips after the synced input has disagreed with it for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0      <= 1'b1;
            sync_1      <= 1'b1;
            level_n     <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_0      <= key_n;
            sync_1      <= sync_0;
            press_pulse <= 1'b0;
            if (sync_1 == level_n) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_n     <= sync_1;
                cnt         <= '0;
                press_pulse <= ~sync_1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pressed = ~level_n;

endmodule

// File: rtl/freq_key_ctrl.sv
// Up/down key control of the overlay frequency: debounce, single step plus auto-repeat, frame-aligned publish.
// Build option: define FREQ_WRAP_EN to wrap between FREQ_MIN and FREQ_MAX instead of saturating.
module freq_key_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int                DEBOUNCE_CYC     = 1_000_000,
    parameter int                REPEAT_DELAY_CYC = 25_000_000,
    parameter int                REPEAT_RATE_CYC  = 5_000_000,
    parameter logic [FREQ_W-1:0] FREQ_MIN         = FREQ_MIN_DEF,
    parameter logic [FREQ_W-1:0] FREQ_MAX         = FREQ_MAX_DEF,
    parameter logic [FREQ_W-1:0] FREQ_INIT        = FREQ_INIT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_up_n,
    input  logic              key_down_n,
    input  logic              frame_start,
    output logic [FREQ_W-1:0] freq_num,
    output logic              freq_changed
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYC - 1);

    logic              up_pressed;
    logic              up_press;
    logic              down_pressed;
    logic              down_press;
    state_t            state;
    state_t            state_nxt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_cnt_nxt;
    logic              dir_up;
    logic              dir_up_nxt;
    logic              step_en;
    logic              own_pressed;
    logic              other_pressed;
    logic [FREQ_W-1:0] freq_work;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up_db (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .key_n       (key_up_n),
        .pressed     (up_pressed),
        .press_pulse (up_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_down_db (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .key_n       (key_down_n),
        .pressed     (down_pressed),
        .press_pulse (down_press)
    );

    assign own_pressed   = dir_up ? up_pressed   : down_pressed;
    assign other_pressed = dir_up ? down_pressed : up_pressed;

    // A second key during a hold locks out stepping until both keys are released.
    always_comb begin
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        dir_up_nxt  = dir_up;
        step_en     = 1'b0;
        case (state)
            IDLE: begin
                rpt_cnt_nxt = '0;
                if (up_pressed && down_pressed) begin
                    state_nxt = LOCK;
                end else if (up_press) begin
                    step_en    = 1'b1;
                    dir_up_nxt = 1'b1;
                    state_nxt  = DELAY;
                end else if (down_press) begin
                    step_en    = 1'b1;
                    dir_up_nxt = 1'b0;
                    state_nxt  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (other_pressed) begin
                    state_nxt   = LOCK;
                    rpt_cnt_nxt = '0;
                end else if (!own_pressed) begin
                    state_nxt   = IDLE;
                    rpt_cnt_nxt = '0;
                end else if (rpt_cnt == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    step_en     = 1'b1;
                    rpt_cnt_nxt = '0;
                    state_nxt   = REPEAT;
                end
            end
            LOCK: begin
                rpt_cnt_nxt = '0;
                if (!up_pressed && !down_pressed) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                rpt_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            rpt_cnt   <= '0;
            dir_up    <= 1'b1;
            freq_work <= FREQ_INIT;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
            dir_up  <= dir_up_nxt;
            if (step_en) begin
                freq_work <= step_freq(freq_work, dir_up_nxt, FREQ_MIN, FREQ_MAX);
            end
        end
    end

    // The shadow samples the registered working value, so a same-cycle step shows one frame later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            freq_num     <= FREQ_INIT;
            freq_changed <= 1'b0;
        end else begin
            freq_changed <= frame_start && (freq_work != freq_num);
            if (frame_start) begin
                freq_num <= freq_work;
            end
        end
    end

endmodule

// File: tb/tb_freq_key_ctrl.sv
// Directed self-checking bench for freq_key_ctrl with short debounce/repeat timing.
// Define FREQ_WRAP_EN for both bench and RTL to exercise the wrap build.
module tb_freq_key_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       key_up_n;
    logic       key_down_n;
    logic       frame_start;
    logic [6:0] freq_num;
    logic       freq_changed;

    int checks = 0;
    int passed = 0;

    freq_key_ctrl #(
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (20),
        .REPEAT_RATE_CYC  (5)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_up_n     (key_up_n),
        .key_down_n   (key_down_n),
        .frame_start  (frame_start),
        .freq_num     (freq_num),
        .freq_changed (freq_changed)
    );

    always #5 sys_clk = ~sys_clk;

    // Everything is driven and sampled 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        sys_rst     = 1'b1;
        key_up_n    = 1'b1;
        key_down_n  = 1'b1;
        frame_start = 1'b0;
        tick(3);
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL reset_num: got %0d expected 20", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL reset_changed: got %b expected 0", freq_changed);
        else passed++;
        sys_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            frame_start = (i == 10);
            tick(1);
            if (freq_changed !== 1'b0) seen = 1'b1;
        end
        frame_start = 1'b0;
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL idle_changed: got 1 expected 0");
        else passed++;
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL idle_num: got %0d expected 20", freq_num);
        else passed++;
    endtask

    task automatic test_glitch();
        key_up_n = 1'b0;
        tick(2);
        key_up_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL glitch_num: got %0d expected 20", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL glitch_changed: got %b expected 0", freq_changed);
        else passed++;
    endtask

    // Step lands on edge 7 after the press; a frame on edge 7 still sees 20, one on edge 8 sees 21.
    task automatic test_single_step();
        key_up_n = 1'b0;
        tick(6);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL step_edge7_num: got %0d expected 20", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL step_edge7_changed: got %b expected 0", freq_changed);
        else passed++;
        pulse_frame();
        checks++;
        if (freq_num !== 7'd21) $display("[TB] FAIL step_edge8_num: got %0d expected 21", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b1) $display("[TB] FAIL step_edge8_changed: got %b expected 1", freq_changed);
        else passed++;
        tick(1);
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL step_pulse_len: got %b expected 0", freq_changed);
        else passed++;
        tick(3);
        key_up_n = 1'b1;
        tick(12);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd21) $display("[TB] FAIL step_release_num: got %0d expected 21", freq_num);
        else passed++;
    endtask

`ifdef FREQ_WRAP_EN
    task automatic test_wrap();
        sys_rst = 1'b1;
        tick(1);
        sys_rst    = 1'b0;
        key_down_n = 1'b0;
        tick(10);
        key_down_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd50) $display("[TB] FAIL wrap_down: got %0d expected 50", freq_num);
        else passed++;
        key_up_n = 1'b0;
        tick(10);
        key_up_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL wrap_up: got %0d expected 20", freq_num);
        else passed++;
    endtask
`else
    task automatic test_down_saturation();
        key_down_n = 1'b0;
        tick(10);
        key_down_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL down_sat_num: got %0d expected 20", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL down_sat_changed: got %b expected 0", freq_changed);
        else passed++;
    endtask

    // From 21: 22 at edge 7, 23 at edge 27, then +1 every 5 edges, reaching 50 at edge 162.
    task automatic test_auto_repeat();
        key_up_n = 1'b0;
        tick(26);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd22) $display("[TB] FAIL rpt_edge27: got %0d expected 22", freq_num);
        else passed++;
        pulse_frame();
        checks++;
        if (freq_num !== 7'd23) $display("[TB] FAIL rpt_edge28: got %0d expected 23", freq_num);
        else passed++;
        tick(21);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd27) $display("[TB] FAIL rpt_edge50: got %0d expected 27", freq_num);
        else passed++;
        tick(150);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd50) $display("[TB] FAIL rpt_saturate: got %0d expected 50", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b1) $display("[TB] FAIL rpt_sat_changed: got %b expected 1", freq_changed);
        else passed++;
        key_up_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL rpt_release_changed: got %b expected 0", freq_changed);
        else passed++;
    endtask

    task automatic test_lock();
        key_down_n = 1'b0;
        tick(10);
        key_up_n = 1'b0;
        tick(40);
        key_up_n = 1'b1;
        tick(40);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd49) $display("[TB] FAIL lock_num: got %0d expected 49", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b1) $display("[TB] FAIL lock_changed: got %b expected 1", freq_changed);
        else passed++;
        key_down_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd49) $display("[TB] FAIL lock_release_num: got %0d expected 49", freq_num);
        else passed++;
        key_down_n = 1'b0;
        tick(10);
        key_down_n = 1'b1;
        tick(10);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd48) $display("[TB] FAIL unlock_step: got %0d expected 48", freq_num);
        else passed++;
    endtask

    task automatic test_reset_mid_hold();
        key_up_n = 1'b0;
        tick(30);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd50) $display("[TB] FAIL hold_pre_reset: got %0d expected 50", freq_num);
        else passed++;
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL hold_reset_num: got %0d expected 20", freq_num);
        else passed++;
        checks++;
        if (freq_changed !== 1'b0) $display("[TB] FAIL hold_reset_changed: got %b expected 0", freq_changed);
        else passed++;
        tick(6);
        pulse_frame();
        checks++;
        if (freq_num !== 7'd20) $display("[TB] FAIL redebounce_edge7: got %0d expected 20", freq_num);
        else passed++;
        pulse_frame();
        checks++;
        if (freq_num !== 7'd21) $display("[TB] FAIL redebounce_edge8: got %0d expected 21", freq_num);
        else passed++;
        key_up_n = 1'b1;
        tick(10);
    endtask
`endif

    initial begin
        test_reset();
`ifdef FREQ_WRAP_EN
        test_glitch();
        test_single_step();
        test_wrap();
`else
        test_down_saturation();
        test_glitch();
        test_single_step();
        test_auto_repeat();
        test_lock();
        test_reset_mid_hold();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/freq_key_ctrl.md
Name: freq_key_ctrl

Overview:
- Upstream control stage for the frequency text overlay.
- Debounces two raw push-buttons (up/down) and applies single-step and auto-repeat increments/decrements to a working frequency value, saturated to 20..50 kHz.
- Publishes the value as freq_num, which feeds the overlay's 7-bit frequency input (valid range 20..50).
- freq_num updates only on a frame-start pulse, so the digits never change mid-frame.

Parameters:
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required before a debounced level change (20 ms at 50 MHz).
- REPEAT_DELAY_CYC, 25_000_000, cycles from the first step to the first auto-repeat step.
- REPEAT_RATE_CYC, 5_000_000, cycles between subsequent auto-repeat steps.
- FREQ_MIN, 7'd20, lower limit.
- FREQ_MAX, 7'd50, upper limit.
- FREQ_INIT, 7'd20, reset value; must satisfy FREQ_MIN <= FREQ_INIT <= FREQ_MAX.

Ports:
- sys_clk  in  1  system/pixel clock.
- sys_rst  in  1  synchronous reset, active-high.
- key_up_n  in  1  raw up button, active-low, asynchronous.
- key_down_n  in  1  raw down button, active-low, asynchronous.
- frame_start  in  1  one-cycle pulse at the start of each LCD frame (vertical blank).
- freq_num  out  7  displayed frequency, FREQ_MIN..FREQ_MAX.
- freq_changed  out  1  one-cycle pulse when freq_num takes a new, different value.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - freq_work = freq_num = FREQ_INIT.
  - freq_changed = 0.
  - Synchronizer flops = 1 (released); debounced levels = released; counters = 0; FSM = IDLE.
  - Reset mid-hold abandons the repeat. A key still held after reset must re-debounce before it steps.
- Synchronisation: each key passes through a 2-flop synchronizer.
- Debounce (per key):
  - Counter increments while the synced level differs from the debounced level; it clears on any cycle where they agree.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC never change the level.
- A "step" is +1 (up) or -1 (down) applied to freq_work, with saturation:
  - up at FREQ_MAX stays FREQ_MAX; down at FREQ_MIN stays FREQ_MIN.
  - No wrap unless the optional feature is enabled.
  - Arithmetic is 8-bit internally to avoid overflow before clamping.
- FSM states: IDLE, DELAY, REPEAT, LOCK; one shared repeat counter.
  - IDLE: exactly one key becomes debounced-pressed -> issue one step in that cycle, clear counter, go to DELAY. Both pressed -> LOCK.
  - DELAY: key released -> IDLE. Other key also pressed -> LOCK. Counter reaches REPEAT_DELAY_CYC-1 -> step, clear counter, go to REPEAT.
  - REPEAT: key released -> IDLE. Other key pressed -> LOCK. Counter reaches REPEAT_RATE_CYC-1 -> step, clear counter.
  - LOCK: no steps. Go to IDLE only when both keys are debounced-released.
- Latency:
  - A raw key edge held stable reaches freq_work after 2 (sync) + DEBOUNCE_CYC + 1 cycles.
  - freq_work reaches freq_num on the first frame_start after that.
- Display shadow:
  - On frame_start, freq_num <= freq_work using the registered freq_work value. A step in the same cycle appears at the next frame_start.
  - freq_changed = 1 for one cycle, the cycle after that update, only if the new freq_num differs from the old one.
  - With no frame_start pulses, freq_num holds indefinitely while freq_work keeps tracking keys.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro FREQ_WRAP_EN.
- Defined: up at FREQ_MAX goes to FREQ_MIN, and down at FREQ_MIN goes to FREQ_MAX. Auto-repeat continues through the wrap.
- Undefined: saturating behaviour as above.

Decomposition:
- Shared package freq_ctrl_pkg holds:
  - FREQ_MIN / FREQ_MAX / FREQ_INIT defaults and the 7-bit frequency width constant.
  - FSM state encoding (IDLE, DELAY, REPEAT, LOCK as 2-bit localparams).
- One sub-module, key_debounce, instantiated twice: synchronizer plus debounce counter. It outputs the debounced level and a one-cycle press-edge pulse.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, frame_start every 50 cycles):
- Reset then idle -> freq_num=20 and freq_changed=0 throughout. key_down held 10 cycles -> freq_work stays 20 (saturation).
- key_up low 2 cycles (glitch) -> no step. key_up low 30 cycles -> freq_work=21 at cycle 2+4+1. freq_num=21 at the next frame_start, then one freq_changed pulse.
- key_up held 200 cycles from 25 -> steps at first debounce, +20, then every 5 cycles -> freq_work saturates at 50. freq_num shows only frame-aligned samples.
- key_up held, then key_down pressed during DELAY -> no further steps (LOCK). Release key_down only -> still no steps. Release both, then press key_down -> one decrement.
- Frame_start coincident with a step cycle -> freq_num takes the pre-step value; the post-step value appears one frame later. sys_rst asserted while key held -> freq_num=20 next cycle, with no step until the key re-debounces.
- With FREQ_WRAP_EN: freq_work=50 and key_up pressed -> 20. freq_work=20 and key_down pressed -> 50.
